// File: rtl/cp0_pkg.sv
// ----------------------------------------------------------------------------
// cp0_pkg
// Constants shared by the CP0 register file and its write initiators:
//   - ExcCode values written to Cause.ExcCode
//   - CP0 register indices (bit positions in the cp0_we strobe vector)
//   - Status / Cause field positions
//   - per-instruction exception flag positions inside mem_exc
//   - exception commit FSM state encoding
// ----------------------------------------------------------------------------
package cp0_pkg;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // CP0 register indices
    localparam int CP0_BADVADDR = 8;
    localparam int CP0_COUNT    = 9;
    localparam int CP0_STATUS   = 12;
    localparam int CP0_CAUSE    = 13;
    localparam int CP0_EPC      = 14;
    localparam int CP0_PRID     = 15;
    localparam int CP0_CONFIG   = 16;

    // Status fields
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    // Cause fields (software interrupt pending bits IP1..IP0)
    localparam int CAUSE_IP_SW_LO = 8;
    localparam int CAUSE_IP_SW_HI = 9;

    // mem_exc flag positions
    localparam int MEXC_DATA    = 0;
    localparam int MEXC_BP      = 1;
    localparam int MEXC_SYS     = 2;
    localparam int MEXC_OV      = 3;
    localparam int MEXC_RI      = 4;
    localparam int MEXC_ADEL_IF = 5;
    localparam int MEXC_ERET    = 6;

    // Commit FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2
    } exc_state_t;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// ----------------------------------------------------------------------------
// int_sync
// Parameterised two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk  in       clock
//   rst  in       asynchronous active-high reset (clears both stages)
//   d    in  [N]  asynchronous inputs
//   q    out [N]  synchronised outputs (two-cycle latency)
// ----------------------------------------------------------------------------
module int_sync #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta_r;
    logic [N-1:0] sync_r;

    // Two back-to-back capture stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl
// Exception / interrupt commit controller at the MEM/WB boundary. Prioritises
// per-instruction exceptions and hardware interrupts, drives one-cycle CP0
// write strobes with the EPC/BadVAddr/ExcCode/BD/EXL payload, redirects the
// PC and flushes IF..MEM. Also commits ERET (clear EXL, return to EPC).
//
// Optional build macro: EXC_CTRL_TIMER_INT_EN adds a sticky Count/Compare
// timer interrupt ORed into IP7 (hw_int_sync[5]).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_valid/pc/bd          MEM-stage instruction valid, PC, delay-slot flag
//   mem_exc[6:0]             {eret, adel_if, ri, ov, sys, bp, data_err}
//   mem_ld_st_err/ades/daddr data address error, store(1)/load(0), address
//   hw_int[5:0]              asynchronous interrupt lines
//   status_in/cause_in/epc_in current CP0 Status, Cause, EPC
//   count_in/compare_in/compare_wr  (timer option only)
//   cp0_we                   one-cycle CP0 write strobes (bits 8,12,13,14)
//   epc_out/badvaddr_out/exc_code/bd_out/exl_out  CP0 payload (held)
//   hw_int_sync              synchronised interrupt lines for Cause.IP
//   redirect_valid/pc        one-cycle PC redirect
//   flush                    squash IF..MEM
// ----------------------------------------------------------------------------
module exc_ctrl
    import cp0_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_bd,
    input  logic [6:0]       mem_exc,
    input  logic             mem_ld_st_err,
    input  logic             mem_ades,
    input  logic [WIDTH-1:0] mem_daddr,
    input  logic [5:0]       hw_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
`ifdef EXC_CTRL_TIMER_INT_EN
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] compare_in,
    input  logic             compare_wr,
`endif
    output logic [WIDTH-1:0] cp0_we,
    output logic [WIDTH-1:0] epc_out,
    output logic [WIDTH-1:0] badvaddr_out,
    output logic [4:0]       exc_code,
    output logic             bd_out,
    output logic             exl_out,
    output logic [5:0]       hw_int_sync,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush
);

    // FLUSH state is entered with this many flush cycles still to go.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    // One-hot CP0 write strobe for register index idx.
    function automatic logic [WIDTH-1:0] we_bit(input int idx);
        logic [WIDTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    exc_state_t       state_r;
    exc_state_t       state_next_s;
    logic [2:0]       cnt_r;
    logic [2:0]       cnt_next_s;

    logic [5:0]       hw_sync_s;
    logic [5:0]       ip_hw_s;
    logic             int_pend_s;
    logic             data_err_s;

    logic             exc_hit_s;
    logic             eret_hit_s;
    logic             addr_err_s;
    logic             fetch_err_s;
    logic [4:0]       code_s;
    logic [WIDTH-1:0] we_exc_s;

    logic             take_exc_s;
    logic             take_eret_s;
    logic             flush_next_s;

    logic             unused_s;

    int_sync #(
        .N (6)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (hw_int),
        .q   (hw_sync_s)
    );

`ifdef EXC_CTRL_TIMER_INT_EN
    logic timer_pending_r;
    logic timer_match_s;

    // A Compare of zero means the timer is disarmed.
    assign timer_match_s = (count_in == compare_in) && (compare_in != '0);

    // Sticky timer interrupt; a Compare write wins over a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_pending_r <= 1'b0;
        end else if (compare_wr) begin
            timer_pending_r <= 1'b0;
        end else if (timer_match_s) begin
            timer_pending_r <= 1'b1;
        end
    end

    assign ip_hw_s = {hw_sync_s[5] | timer_pending_r, hw_sync_s[4:0]};
`else
    assign ip_hw_s = hw_sync_s;
`endif

    assign hw_int_sync = ip_hw_s;

    // IE set, EXL clear, and some unmasked line among {IP7..IP2, IP1..IP0}.
    assign int_pend_s = status_in[STATUS_IE] & ~status_in[STATUS_EXL] &
                        (|({ip_hw_s, cause_in[CAUSE_IP_SW_HI:CAUSE_IP_SW_LO]} &
                           status_in[STATUS_IM_HI:STATUS_IM_LO]));

    // A data address error may be flagged by either the MEM exception bit or
    // the dedicated load/store error line.
    assign data_err_s = mem_exc[MEXC_DATA] | mem_ld_st_err;

    // Fixed-priority selection of the winning event; ERET only if nothing else.
    always_comb begin
        exc_hit_s   = 1'b1;
        eret_hit_s  = 1'b0;
        addr_err_s  = 1'b0;
        fetch_err_s = 1'b0;
        code_s      = EXC_INT;
        if (int_pend_s) begin
            code_s = EXC_INT;
        end else if (mem_exc[MEXC_ADEL_IF]) begin
            code_s      = EXC_ADEL;
            addr_err_s  = 1'b1;
            fetch_err_s = 1'b1;
        end else if (mem_exc[MEXC_RI]) begin
            code_s = EXC_RI;
        end else if (mem_exc[MEXC_OV]) begin
            code_s = EXC_OV;
        end else if (mem_exc[MEXC_SYS]) begin
            code_s = EXC_SYS;
        end else if (mem_exc[MEXC_BP]) begin
            code_s = EXC_BP;
        end else if (data_err_s) begin
            code_s     = mem_ades ? EXC_ADES : EXC_ADEL;
            addr_err_s = 1'b1;
        end else if (mem_exc[MEXC_ERET]) begin
            exc_hit_s  = 1'b0;
            eret_hit_s = 1'b1;
        end else begin
            exc_hit_s = 1'b0;
        end
    end

    // Exception write set: Status, Cause, EPC, plus BadVAddr on address errors.
    always_comb begin
        we_exc_s = we_bit(CP0_STATUS) | we_bit(CP0_CAUSE) | we_bit(CP0_EPC);
        if (addr_err_s) begin
            we_exc_s = we_exc_s | we_bit(CP0_BADVADDR);
        end else begin
            we_exc_s = we_exc_s;
        end
    end

    // Next-state logic; MEM inputs are only looked at in IDLE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        take_exc_s   = 1'b0;
        take_eret_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid && exc_hit_s) begin
                    take_exc_s   = 1'b1;
                    state_next_s = ST_COMMIT;
                end else if (mem_valid && eret_hit_s) begin
                    take_eret_s  = 1'b1;
                    state_next_s = ST_COMMIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_FLUSH;
                cnt_next_s   = FLUSH_LOAD;
            end
            ST_FLUSH: begin
                if (cnt_r <= 3'd1) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 3'd0;
                end else begin
                    cnt_next_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // Flush is high throughout COMMIT and while FLUSH still has cycles left.
    assign flush_next_s = (state_next_s == ST_COMMIT) ||
                          ((state_next_s == ST_FLUSH) && (cnt_next_s != 3'd0));

    // State register and flush down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered outputs: strobes pulse for the COMMIT cycle, payload holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp0_we         <= '0;
            epc_out        <= '0;
            badvaddr_out   <= '0;
            exc_code       <= 5'd0;
            bd_out         <= 1'b0;
            exl_out        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            cp0_we         <= '0;
            redirect_valid <= 1'b0;
            flush          <= flush_next_s;
            if (take_exc_s) begin
                cp0_we         <= we_exc_s;
                // Delay-slot faults restart at the branch; wraps modulo 2^WIDTH.
                epc_out        <= mem_bd ? (mem_pc - WIDTH'(32'd4)) : mem_pc;
                badvaddr_out   <= fetch_err_s ? mem_pc : mem_daddr;
                exc_code       <= code_s;
                bd_out         <= mem_bd;
                exl_out        <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= EXC_VECTOR;
            end else if (take_eret_s) begin
                cp0_we         <= we_bit(CP0_STATUS);
                exl_out        <= 1'b0;
                redirect_valid <= 1'b1;
                redirect_pc    <= epc_in;
            end
        end
    end

    // Register fields this controller does not consume.
    assign unused_s = &{1'b0, status_in[WIDTH-1:STATUS_IM_HI+1],
                        status_in[STATUS_IM_LO-1:STATUS_EXL+1],
                        cause_in[WIDTH-1:CAUSE_IP_SW_HI+1],
                        cause_in[CAUSE_IP_SW_LO-1:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mem_valid = 1'b0;
    logic [WIDTH-1:0] mem_pc = 32'd0;
    logic             mem_bd = 1'b0;
    logic [6:0]       mem_exc = 7'd0;
    logic             mem_ld_st_err = 1'b0;
    logic             mem_ades = 1'b0;
    logic [WIDTH-1:0] mem_daddr = 32'd0;
    logic [5:0]       hw_int = 6'd0;
    logic [WIDTH-1:0] status_in = 32'd0;
    logic [WIDTH-1:0] cause_in = 32'd0;
    logic [WIDTH-1:0] epc_in = 32'd0;
`ifdef EXC_CTRL_TIMER_INT_EN
    logic [WIDTH-1:0] count_in = 32'd0;
    logic [WIDTH-1:0] compare_in = 32'd0;
    logic             compare_wr = 1'b0;
`endif
    logic [WIDTH-1:0] cp0_we;
    logic [WIDTH-1:0] epc_out;
    logic [WIDTH-1:0] badvaddr_out;
    logic [4:0]       exc_code;
    logic             bd_out;
    logic             exl_out;
    logic [5:0]       hw_int_sync;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             flush;

    exc_ctrl #(
        .WIDTH        (32),
        .EXC_VECTOR   (32'hBFC0_0380),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .mem_exc        (mem_exc),
        .mem_ld_st_err  (mem_ld_st_err),
        .mem_ades       (mem_ades),
        .mem_daddr      (mem_daddr),
        .hw_int         (hw_int),
        .status_in      (status_in),
        .cause_in       (cause_in),
        .epc_in         (epc_in),
`ifdef EXC_CTRL_TIMER_INT_EN
        .count_in       (count_in),
        .compare_in     (compare_in),
        .compare_wr     (compare_wr),
`endif
        .cp0_we         (cp0_we),
        .epc_out        (epc_out),
        .badvaddr_out   (badvaddr_out),
        .exc_code       (exc_code),
        .bd_out         (bd_out),
        .exl_out        (exl_out),
        .hw_int_sync    (hw_int_sync),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string       name;
        logic [31:0] we;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [4:0]  code;
        logic        bd;
        logic        exl;
        logic [31:0] rpc;
        int          cyc;
        bit          chk_flush;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [31:0] WE_EXC  = 32'h0000_7000;
    localparam logic [31:0] WE_ADDR = 32'h0000_7100;
    localparam logic [31:0] WE_ERET = 32'h0000_1000;
    localparam logic [31:0] VEC     = 32'hBFC0_0380;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [31:0] we, input logic [31:0] epc,
                                input logic [31:0] bad, input logic [4:0] code, input logic bd,
                                input logic exl, input logic [31:0] rpc, input bit chk_flush);
        exp_t e;
        e.name = name; e.we = we; e.epc = epc; e.bad = bad; e.code = code;
        e.bd = bd; e.exl = exl; e.rpc = rpc; e.cyc = 0; e.chk_flush = chk_flush;
        return e;
    endfunction

    // Expected commit lands lat rising edges after the current negedge.
    task automatic push(input exp_t e, input int lat);
        e.cyc = cyc_cnt + lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_commit(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (redirect_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s.timeout: got no commit expected one within 20 cycles", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic clear_mem();
        mem_valid = 1'b0; mem_exc = 7'd0; mem_ld_st_err = 1'b0; mem_ades = 1'b0; mem_bd = 1'b0;
    endtask

    task automatic settle();
        clear_mem();
        repeat (4) @(negedge clk);
    endtask

    // Drive one MEM-stage event, push its expectation, wait for the commit.
    task automatic event_vec(input logic [6:0] exc, input logic lse, input logic ades,
                             input logic bd, input logic [31:0] pc, input logic [31:0] da,
                             input exp_t e);
        @(negedge clk);
        mem_valid = 1'b1; mem_exc = exc; mem_ld_st_err = lse; mem_ades = ades;
        mem_bd = bd; mem_pc = pc; mem_daddr = da;
        push(e, 1);
        wait_commit(e.name);
    endtask

    // Monitor: every redirect pulse is matched against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (redirect_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_commit: got redirect to %h expected none", redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".cycle"}, 32'(cyc_cnt), 32'(e.cyc));
                    chk({e.name, ".cp0_we"}, cp0_we, e.we);
                    chk({e.name, ".epc"}, epc_out, e.epc);
                    chk({e.name, ".badvaddr"}, badvaddr_out, e.bad);
                    chk({e.name, ".exc_code"}, 32'(exc_code), 32'(e.code));
                    chk({e.name, ".bd"}, 32'(bd_out), 32'(e.bd));
                    chk({e.name, ".exl"}, 32'(exl_out), 32'(e.exl));
                    chk({e.name, ".redirect_pc"}, redirect_pc, e.rpc);
                    chk({e.name, ".flush0"}, 32'(flush), 32'd1);
                    if (e.chk_flush) begin
                        @(negedge clk);
                        chk({e.name, ".flush1"}, 32'(flush), 32'd1);
                        chk({e.name, ".we_pulse"}, cp0_we, 32'd0);
                        chk({e.name, ".rv_pulse"}, 32'(redirect_valid), 32'd0);
                        @(negedge clk);
                        chk({e.name, ".flush2"}, 32'(flush), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int fires;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.cp0_we", cp0_we, 32'd0);
        chk("rst.epc", epc_out, 32'd0);
        chk("rst.redirect", {31'd0, redirect_valid} | redirect_pc, 32'd0);
        chk("rst.flags", {21'd0, exc_code, bd_out, exl_out, flush, hw_int_sync[2:0]}, 32'd0);

        // Hardware interrupt: two sync stages, then commit one cycle later.
        @(negedge clk);
        hw_int = 6'b000001; status_in = 32'h0000_0401; cause_in = 32'd0;
        mem_valid = 1'b1; mem_pc = 32'h8000_0010; mem_daddr = 32'd0;
        push(mk("int", WE_EXC, 32'h8000_0010, 32'd0, 5'd0, 1'b0, 1'b1, VEC, 1'b1), 3);
        @(negedge clk);
        chk("int.sync_stage1", 32'(hw_int_sync), 32'd0);
        @(negedge clk);
        chk("int.sync_stage2", 32'(hw_int_sync), 32'd1);
        wait_commit("int");
        hw_int = 6'd0; status_in = 32'd0;
        settle();

        // Ov beats Sys; delay slot rewinds EPC.
        event_vec(7'b0001100, 1'b0, 1'b0, 1'b1, 32'h8000_0104, 32'h1234_5678,
                  mk("ov_sys_bd", WE_EXC, 32'h8000_0100, 32'h1234_5678, 5'd12, 1'b1, 1'b1, VEC, 1'b1));
        settle();
        event_vec(7'b0000001, 1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h0000_1003,
                  mk("ades", WE_ADDR, 32'h8000_0200, 32'h0000_1003, 5'd5, 1'b0, 1'b1, VEC, 1'b1));
        settle();
        event_vec(7'b0000001, 1'b1, 1'b0, 1'b0, 32'h8000_0204, 32'h0000_2002,
                  mk("adel_ld", WE_ADDR, 32'h8000_0204, 32'h0000_2002, 5'd4, 1'b0, 1'b1, VEC, 1'b1));
        settle();
        event_vec(7'b0110000, 1'b0, 1'b0, 1'b0, 32'h8000_0300, 32'h0000_0055,
                  mk("adel_if", WE_ADDR, 32'h8000_0300, 32'h8000_0300, 5'd4, 1'b0, 1'b1, VEC, 1'b1));
        settle();
        event_vec(7'b0000010, 1'b0, 1'b0, 1'b0, 32'h8000_0400, 32'd0,
                  mk("bp", WE_EXC, 32'h8000_0400, 32'd0, 5'd9, 1'b0, 1'b1, VEC, 1'b1));
        settle();

        // ERET: only Status written, payload held from the bp commit.
        epc_in = 32'h8000_2000;
        event_vec(7'b1000000, 1'b0, 1'b0, 1'b0, 32'h8000_0480, 32'd0,
                  mk("eret", WE_ERET, 32'h8000_0400, 32'd0, 5'd9, 1'b0, 1'b0, 32'h8000_2000, 1'b1));
        settle();

        // ERET alongside a raised line while EXL=1 stays an ERET.
        status_in = 32'h0000_0403; hw_int = 6'b000001;
        repeat (3) @(negedge clk);
        epc_in = 32'h8000_3000;
        event_vec(7'b1000000, 1'b0, 1'b0, 1'b0, 32'h8000_0490, 32'd0,
                  mk("eret_exl_int", WE_ERET, 32'h8000_0400, 32'd0, 5'd9, 1'b0, 1'b0, 32'h8000_3000, 1'b1));
        hw_int = 6'd0; status_in = 32'd0;
        settle();

        // ERET squashed by Sys.
        event_vec(7'b1000100, 1'b0, 1'b0, 1'b0, 32'h8000_0500, 32'd0,
                  mk("eret_sys", WE_EXC, 32'h8000_0500, 32'd0, 5'd8, 1'b0, 1'b1, VEC, 1'b1));
        settle();

        // PC-4 wraps.
        event_vec(7'b0010000, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'd0,
                  mk("ri_wrap", WE_EXC, 32'hFFFF_FFFC, 32'd0, 5'd10, 1'b1, 1'b1, VEC, 1'b1));
        settle();

        // Reset during FLUSH clears everything asynchronously.
        event_vec(7'b0000010, 1'b0, 1'b0, 1'b0, 32'h8000_0600, 32'd0,
                  mk("bp_rst", WE_EXC, 32'h8000_0600, 32'd0, 5'd9, 1'b0, 1'b1, VEC, 1'b0));
        clear_mem();
        @(negedge clk);
        chk("rst_mid.flush_before", 32'(flush), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.flush", 32'(flush), 32'd0);
        chk("rst_mid.payload", epc_out | badvaddr_out | redirect_pc | cp0_we, 32'd0);
        chk("rst_mid.flags", {25'd0, exc_code, bd_out, exl_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        event_vec(7'b0000100, 1'b0, 1'b0, 1'b0, 32'h8000_0700, 32'd0,
                  mk("sys_after_rst", WE_EXC, 32'h8000_0700, 32'd0, 5'd8, 1'b0, 1'b1, VEC, 1'b1));
        settle();

`ifdef EXC_CTRL_TIMER_INT_EN
        // Same-cycle set and clear resolves to clear.
        @(negedge clk);
        count_in = 32'd50; compare_in = 32'd50; compare_wr = 1'b1;
        @(negedge clk);
        compare_wr = 1'b0; count_in = 32'd0;
        chk("timer.set_clr", 32'(hw_int_sync), 32'd0);

        // Timer match raises IP7 and is taken as an interrupt.
        status_in = 32'h0000_8001;
        count_in = 32'd100; compare_in = 32'd100;
        mem_valid = 1'b1; mem_pc = 32'h8000_0800; mem_daddr = 32'd0;
        push(mk("timer", WE_EXC, 32'h8000_0800, 32'd0, 5'd0, 1'b0, 1'b1, VEC, 1'b1), 2);
        wait_commit("timer");
        mem_valid = 1'b0; count_in = 32'd0; compare_wr = 1'b1;
        @(negedge clk);
        compare_wr = 1'b0;
        chk("timer.cleared", 32'(hw_int_sync), 32'd0);
        repeat (3) @(negedge clk);
        mem_valid = 1'b1; mem_pc = 32'h8000_0900;
        fires = 0;
        repeat (10) begin
            @(negedge clk);
            if (redirect_valid === 1'b1) fires++;
        end
        chk("timer.no_refire", 32'(fires), 32'd0);
        status_in = 32'd0;
        settle();
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt commit controller; the initiator side of the CP0 register-file write interface.
- Sits at the MEM/WB boundary. Collects per-instruction exception flags and asynchronous hardware interrupts, then prioritises them.
- Drives the CP0 write-enable vector and payload (EPC, BadVAddr, ExcCode, BD, EXL) for exactly one cycle.
- Redirects the PC and flushes the pipeline; also handles ERET return.

Parameters:
- WIDTH, 32, datapath width.
- EXC_VECTOR, 32'hBFC00380, exception entry PC.
- FLUSH_CYCLES, 2, cycles flush stays asserted after commit (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  instruction in MEM is valid
- mem_pc  in  WIDTH  PC of MEM instruction
- mem_bd  in  1  MEM instruction is in a delay slot
- mem_exc  in  7  {eret, adel_if, ri, ov, sys, bp, adel_ld/ades sel}; bit0 qualified by mem_ades
- mem_ld_st_err  in  1  data address error present
- mem_ades  in  1  data error is a store (1) or a load (0)
- mem_daddr  in  WIDTH  data virtual address
- hw_int  in  6  asynchronous hardware interrupt lines
- status_in  in  WIDTH  CP0 Status
- cause_in  in  WIDTH  CP0 Cause
- epc_in  in  WIDTH  CP0 EPC
- cp0_we  out  WIDTH  per-register write strobes (bits 8, 12, 13, 14 used)
- epc_out  out  WIDTH  EPC payload
- badvaddr_out  out  WIDTH  BadVAddr payload
- exc_code  out  5  ExcCode payload
- bd_out  out  1  Branch-delay payload
- exl_out  out  1  EXL payload
- hw_int_sync  out  6  synchronised interrupt lines, feeding Cause IP
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  WIDTH  redirect target
- flush  out  1  squash IF..MEM

Behaviour:
- Reset values: all outputs 0; state IDLE; synchroniser flops 0.
- hw_int passes through a 2-flop synchroniser to hw_int_sync.
- Pending interrupt = Status[0] & ~Status[1] & |({hw_int_sync, cause_in[9:8]} & Status[15:8]).
- Interrupts are only taken on a cycle with mem_valid=1, so EPC is always precise.
- Priority, high to low, with ExcCode:
  - Int 0
  - AdEL-fetch 4
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdEL-data 4 / AdES 5
  - ERET, lowest; squashed if anything above it fires.
- FSM states: IDLE, COMMIT, FLUSH.
  - IDLE: on a winning event with mem_valid, register the payload and go to COMMIT. Latency from detection is 1 cycle.
  - COMMIT, exception (one cycle):
    - cp0_we[8,12,13,14]=1; cp0_we[8] only for address errors.
    - epc_out = mem_bd ? pc-4 : pc; bd_out = mem_bd; exl_out=1.
    - badvaddr_out = pc for a fetch error, otherwise mem_daddr.
    - redirect_valid=1, redirect_pc=EXC_VECTOR, flush=1.
  - COMMIT, ERET: cp0_we[12]=1 only, exl_out=0, redirect_pc=epc_in, flush=1.
  - COMMIT always goes to FLUSH.
  - FLUSH: flush=1 for FLUSH_CYCLES-1 further cycles, counted by a 3-bit down-counter; then IDLE. All MEM inputs are ignored in FLUSH.
- cp0_we and redirect_valid are single-cycle pulses. Payload outputs hold their last value until the next COMMIT.
- PC-4 wraps modulo 2^WIDTH.
- Reset asserted mid-COMMIT/FLUSH: outputs clear immediately, no partial write survives.

Optional Feature:
- Macro: EXC_CTRL_TIMER_INT_EN.
- When defined, adds ports count_in (WIDTH, in), compare_in (WIDTH, in) and compare_wr (1, in).
  - A sticky timer_pending flop sets when count_in==compare_in and compare_in!=0.
  - It clears on compare_wr; a same-cycle set and clear resolves to clear.
  - timer_pending is ORed into IP7, i.e. hw_int_sync[5] as seen by the pending logic and the output.
- When not defined: the ports are absent and IP7 is hw_int_sync[5] alone.

Decomposition:
- Shared package cp0_pkg:
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
  - CP0 register indices: 8, 9, 12, 13, 14, 15, 16.
  - FSM state encoding.
  - Status/Cause bit positions.
- Sub-module: int_sync, a parameterised 2-flop synchroniser with asynchronous reset.

Test Plan:
- Reset then hw_int=6'b000001, Status=32'h0000_0401, Cause=0, mem_valid=1, mem_pc=32'h8000_0010 -> 3 cycles later:
  - cp0_we bits 12/13/14 pulse, exc_code=0, epc_out=32'h8000_0010.
  - redirect_pc=32'hBFC0_0380; flush high for 2 cycles.
- ov and sys together, mem_bd=1, mem_pc=32'h8000_0104 -> exc_code=12, epc_out=32'h8000_0100, bd_out=1.
- Store error with mem_daddr=32'h0000_1003 -> exc_code=5, cp0_we[8]=1, badvaddr_out=32'h0000_1003.
- ERET with epc_in=32'h8000_2000 -> only cp0_we[12], exl_out=0, redirect_pc=32'h8000_2000. With Status EXL=1, an ERET arriving together with an interrupt is still an ERET.
- rst pulsed during FLUSH -> flush and all outputs 0 asynchronously; the next event is handled normally.
- With EXC_CTRL_TIMER_INT_EN, Status=32'h0000_8001, count_in==compare_in=32'd100 -> exc_code=0 taken; compare_wr clears pending, and no further interrupt fires.
